burst_sync_controller: RTL and testbench
========================================

Name: burst_sync_controller

Overview:
- Per-burst sequencer for the upstream burst-mode synchronizer in the PON receive path. Sits between the OLT upstream grant scheduler and the synchronizer.
- Driven by a grant pulse, it performs these steps in order: clears the synchronizer shift, enables the syncword search for a bounded window, freezes the alignment on detection, and frames the granted payload with a data-valid strobe.
- Keeps per-burst status and saturating lock/fail statistics for software.

Parameters:
- PIPE_FILL, 4: cycles after sync_reset before detection results are meaningful (buffer + SAD + min-tree latency).
- DATA_LAT, 3: cycles from out_detected rising to first aligned payload word at the synchronizer output.
- LEN_W, 16: width of burst length in 32-bit words.
- WIN_W, 8: width of search window counter.
- STAT_W, 16: width of statistics counters.

Ports:
- in_clock  in  1  datapath clock, GT RX user clock domain
- in_reset_n  in  1  asynchronous, active-low reset
- in_grant  in  1  one-cycle pulse: burst expected to start now
- in_burst_len  in  LEN_W  payload words after delimiter, sampled with in_grant
- in_search_win  in  WIN_W  max cycles in SEARCH, sampled with in_grant
- in_threshold_cfg  in  7  SAD threshold forwarded to synchronizer
- in_detected  in  1  synchronizer out_detected
- in_stat_clear  in  1  synchronous clear of statistics
- out_sync_reset  out  1  to synchronizer in_reset
- out_sync_enable  out  1  to synchronizer in_enable
- out_threshold  out  7  to synchronizer in_threshold, registered copy of cfg
- out_data_valid  out  1  qualifies synchronizer out_data as payload
- out_sof  out  1  first payload word
- out_eof  out  1  last payload word
- out_busy  out  1  state != IDLE
- out_burst_ok  out  1  one-cycle pulse, burst completed
- out_burst_fail  out  1  one-cycle pulse, search timed out
- out_lock_count  out  STAT_W  saturating count of locked bursts
- out_fail_count  out  STAT_W  saturating count of failed bursts
- out_grant_drop  out  STAT_W  saturating count of grants ignored while busy

Behaviour:
- Reset values: all outputs 0, except out_sync_reset = 1. State is IDLE.
- out_threshold register: loads in_threshold_cfg every cycle in IDLE only; held constant during a burst.
- States: IDLE, FLUSH, SEARCH, ALIGN, PAYLOAD, FAIL.
- IDLE:
  - out_sync_reset = 1, enable = 0.
  - On in_grant: latch len and win, go to FLUSH. The fill counter loads PIPE_FILL-1.
- FLUSH:
  - sync_reset = 0, enable = 0.
  - Counts down. At 0, go to SEARCH and load the window counter with the latched win.
- SEARCH:
  - enable = 1.
  - If in_detected = 1: go to ALIGN and load the align counter with DATA_LAT-1. The enable deassertion is registered, so the detecting cycle's shift is captured.
  - Else if the window counter = 0: go to FAIL.
  - Else decrement the window counter.
  - Window 0 means exactly one search cycle.
  - Detection and expiry in the same cycle: detection wins.
- ALIGN:
  - enable = 0; the shift is held by the synchronizer.
  - Counts down. At 0, go to PAYLOAD with the word counter = latched len.
  - in_detected is ignored here.
- PAYLOAD:
  - data_valid = 1 each cycle; the word counter decrements.
  - out_sof accompanies the first valid word.
  - out_eof accompanies the word where the counter = 1; then go to IDLE, pulse out_burst_ok, and increment lock_count.
  - len = 0: skip PAYLOAD. ALIGN exits straight to IDLE with out_burst_ok and no data_valid.
  - len = 1: sof and eof in the same cycle.
- FAIL:
  - One cycle: pulse out_burst_fail, increment fail_count, go to IDLE.
- in_grant while not IDLE: ignored and out_grant_drop increments.
  - Exception: in_grant arriving in the same cycle that PAYLOAD exits to IDLE is also dropped.
  - Acceptance happens only when registered state == IDLE.
- Statistics:
  - Saturate at all-ones.
  - in_stat_clear zeroes them; clear has priority over a simultaneous increment.
- Mid-burst reset: asynchronous return to IDLE with reset values. Strobes drop immediately and no ok/fail pulse is produced.
- All outputs are registered (Moore). Output changes appear one cycle after the transition condition.

Decomposition:
- Shared package pon_rx_pkg:
  - state enum for the six states;
  - default PIPE_FILL and DATA_LAT constants, shared with the synchronizer instantiation.
- One sub-module: sat_counter (STAT_W, inc, clr), instantiated three times.
- The FSM and down-counters stay in the top.

Test Plan:
- Nominal: grant with len = 4, win = 20; in_detected = 1 at SEARCH cycle 5.
  - sync_reset low 1 cycle after grant.
  - enable high for 6 cycles.
  - data_valid for exactly 4 cycles, starting DATA_LAT+1 cycles after the detect.
  - sof on word 1, eof on word 4.
  - burst_ok pulse; lock_count = 1.
- Timeout: grant with win = 3 and no detect.
  - enable high 4 cycles.
  - burst_fail pulse; fail_count = 1; never data_valid.
- Boundary lengths:
  - len = 1: sof and eof coincide.
  - len = 0: burst_ok with no data_valid.
  - Detect on the final window cycle: lock, not fail.
- Grant during PAYLOAD and on the exit cycle: both dropped; grant_drop = 2; next grant in IDLE accepted.
- Saturation and clear:
  - Force lock_count to 0xFFFF, run a burst: stays 0xFFFF.
  - stat_clear with a simultaneous burst_ok: count = 0.
- Async reset during SEARCH and during PAYLOAD:
  - Outputs return to reset values within the same cycle.
  - No ok/fail pulse.
  - Next grant runs a nominal burst.

Source files
------------

// File: rtl/pon_rx_pkg.sv
// Shared PON upstream receive types: burst sequencer states and synchronizer pipeline constants.
// Pure declarations; no latency or backpressure of its own.
package pon_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SEARCH,
    ST_ALIGN,
    ST_PAYLOAD,
    ST_FAIL
  } state_e;

  // Buffer + SAD + min-tree latency, and detect-to-first-aligned-word latency.
  localparam int PIPE_FILL_DEF = 4;
  localparam int DATA_LAT_DEF  = 3;

  localparam int LEN_W_DEF  = 16;
  localparam int WIN_W_DEF  = 8;
  localparam int STAT_W_DEF = 16;
  localparam int THR_W      = 7;
  localparam int PHASE_W    = 8;

endpackage

// File: rtl/burst_sync_controller_if.sv
// Grant-scheduler / synchronizer control bundle for the burst sequencer.
// master drives the in_* side (scheduler, synchronizer status); slave is the sequencer.
interface burst_sync_controller_if
  import pon_rx_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int STAT_W = STAT_W_DEF
);

  logic              in_grant;
  logic [LEN_W-1:0]  in_burst_len;
  logic [WIN_W-1:0]  in_search_win;
  logic [THR_W-1:0]  in_threshold_cfg;
  logic              in_detected;
  logic              in_stat_clear;

  logic              out_sync_reset;
  logic              out_sync_enable;
  logic [THR_W-1:0]  out_threshold;
  logic              out_data_valid;
  logic              out_sof;
  logic              out_eof;
  logic              out_busy;
  logic              out_burst_ok;
  logic              out_burst_fail;
  logic [STAT_W-1:0] out_lock_count;
  logic [STAT_W-1:0] out_fail_count;
  logic [STAT_W-1:0] out_grant_drop;

  modport master (
    output in_grant, in_burst_len, in_search_win, in_threshold_cfg,
           in_detected, in_stat_clear,
    input  out_sync_reset, out_sync_enable, out_threshold, out_data_valid,
           out_sof, out_eof, out_busy, out_burst_ok, out_burst_fail,
           out_lock_count, out_fail_count, out_grant_drop
  );

  modport slave (
    input  in_grant, in_burst_len, in_search_win, in_threshold_cfg,
           in_detected, in_stat_clear,
    output out_sync_reset, out_sync_enable, out_threshold, out_data_valid,
           out_sof, out_eof, out_busy, out_burst_ok, out_burst_fail,
           out_lock_count, out_fail_count, out_grant_drop
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; synchronous clear wins over a coincident increment.
// Count is visible the cycle after in_inc; never stalls.
module sat_counter #(
  parameter int STAT_W = 16
) (
  input  logic              in_clock,
  input  logic              in_reset_n,
  input  logic              in_inc,
  input  logic              in_clr,
  output logic [STAT_W-1:0] out_count
);

  logic [STAT_W-1:0] r_count;
  logic              w_at_max;

  assign w_at_max = (r_count == {STAT_W{1'b1}});

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_count <= '0;
    end else if (in_clr) begin
      r_count <= '0;
    end else if (in_inc && !w_at_max) begin
      r_count <= r_count + STAT_W'(1);
    end
  end

  assign out_count = r_count;

endmodule

// File: rtl/burst_sync_controller.sv
// Per-burst sequencer for the upstream burst-mode synchronizer: flush, bounded search, align, framed payload.
// Registered Moore outputs one cycle behind the transition; grants arriving while busy are dropped and counted.
module burst_sync_controller
  import pon_rx_pkg::*;
#(
  parameter int LEN_W     = LEN_W_DEF,
  parameter int WIN_W     = WIN_W_DEF,
  parameter int STAT_W    = STAT_W_DEF,
  parameter int PIPE_FILL = PIPE_FILL_DEF,
  parameter int DATA_LAT  = DATA_LAT_DEF
) (
  input logic                    in_clock,
  input logic                    in_reset_n,
  burst_sync_controller_if.slave bus
);

  state_e             r_state;
  state_e             w_nxt_state;

  logic [LEN_W-1:0]   r_len;
  logic [WIN_W-1:0]   r_win;
  logic [PHASE_W-1:0] r_fill_cnt;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [PHASE_W-1:0] r_align_cnt;
  logic [LEN_W-1:0]   r_word_cnt;

  logic [PHASE_W-1:0] w_nxt_fill;
  logic [WIN_W-1:0]   w_nxt_win;
  logic [PHASE_W-1:0] w_nxt_align;
  logic [LEN_W-1:0]   w_nxt_word;

  logic               w_ok;
  logic               w_fail;
  logic               w_sof;
  logic               w_drop;

  logic               r_sync_reset;
  logic               r_sync_enable;
  logic [THR_W-1:0]   r_threshold;
  logic               r_data_valid;
  logic               r_sof;
  logic               r_eof;
  logic               r_busy;
  logic               r_burst_ok;
  logic               r_burst_fail;

  // Acceptance keys off the registered state, so a grant on the PAYLOAD exit cycle is a drop.
  assign w_drop = bus.in_grant && (r_state != ST_IDLE);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_fill  = r_fill_cnt;
    w_nxt_win   = r_win_cnt;
    w_nxt_align = r_align_cnt;
    w_nxt_word  = r_word_cnt;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    w_sof       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_grant) begin
          w_nxt_state = ST_FLUSH;
          w_nxt_fill  = PHASE_W'(PIPE_FILL - 1);
        end
      end
      ST_FLUSH: begin
        if (r_fill_cnt == '0) begin
          w_nxt_state = ST_SEARCH;
          w_nxt_win   = r_win;
        end else begin
          w_nxt_fill = r_fill_cnt - PHASE_W'(1);
        end
      end
      ST_SEARCH: begin
        // Detection is checked before expiry so a hit on the last window cycle still locks.
        if (bus.in_detected) begin
          w_nxt_state = ST_ALIGN;
          w_nxt_align = PHASE_W'(DATA_LAT - 1);
        end else if (r_win_cnt == '0) begin
          w_nxt_state = ST_FAIL;
          w_fail      = 1'b1;
        end else begin
          w_nxt_win = r_win_cnt - WIN_W'(1);
        end
      end
      ST_ALIGN: begin
        if (r_align_cnt == '0) begin
          if (r_len == '0) begin
            w_nxt_state = ST_IDLE;
            w_ok        = 1'b1;
          end else begin
            w_nxt_state = ST_PAYLOAD;
            w_nxt_word  = r_len;
            w_sof       = 1'b1;
          end
        end else begin
          w_nxt_align = r_align_cnt - PHASE_W'(1);
        end
      end
      ST_PAYLOAD: begin
        w_nxt_word = r_word_cnt - LEN_W'(1);
        if (r_word_cnt <= LEN_W'(1)) begin
          w_nxt_state = ST_IDLE;
          w_ok        = 1'b1;
        end
      end
      ST_FAIL: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_win       <= '0;
      r_fill_cnt  <= '0;
      r_win_cnt   <= '0;
      r_align_cnt <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_fill_cnt  <= w_nxt_fill;
      r_win_cnt   <= w_nxt_win;
      r_align_cnt <= w_nxt_align;
      r_word_cnt  <= w_nxt_word;
      if ((r_state == ST_IDLE) && bus.in_grant) begin
        r_len <= bus.in_burst_len;
        r_win <= bus.in_search_win;
      end
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_sync_reset  <= 1'b1;
      r_sync_enable <= 1'b0;
      r_threshold   <= '0;
      r_data_valid  <= 1'b0;
      r_sof         <= 1'b0;
      r_eof         <= 1'b0;
      r_busy        <= 1'b0;
      r_burst_ok    <= 1'b0;
      r_burst_fail  <= 1'b0;
    end else begin
      r_sync_reset  <= (w_nxt_state == ST_IDLE);
      r_sync_enable <= (w_nxt_state == ST_SEARCH);
      r_data_valid  <= (w_nxt_state == ST_PAYLOAD);
      r_sof         <= w_sof;
      r_eof         <= (w_nxt_state == ST_PAYLOAD) && (w_nxt_word == LEN_W'(1));
      r_busy        <= (w_nxt_state != ST_IDLE);
      r_burst_ok    <= w_ok;
      r_burst_fail  <= w_fail;
      if (r_state == ST_IDLE) begin
        r_threshold <= bus.in_threshold_cfg;
      end
    end
  end

  assign bus.out_sync_reset  = r_sync_reset;
  assign bus.out_sync_enable = r_sync_enable;
  assign bus.out_threshold   = r_threshold;
  assign bus.out_data_valid  = r_data_valid;
  assign bus.out_sof         = r_sof;
  assign bus.out_eof         = r_eof;
  assign bus.out_busy        = r_busy;
  assign bus.out_burst_ok    = r_burst_ok;
  assign bus.out_burst_fail  = r_burst_fail;

  sat_counter #(.STAT_W(STAT_W)) u_lock_cnt (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .in_inc     (w_ok),
    .in_clr     (bus.in_stat_clear),
    .out_count  (bus.out_lock_count)
  );

  sat_counter #(.STAT_W(STAT_W)) u_fail_cnt (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .in_inc     (w_fail),
    .in_clr     (bus.in_stat_clear),
    .out_count  (bus.out_fail_count)
  );

  sat_counter #(.STAT_W(STAT_W)) u_drop_cnt (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .in_inc     (w_drop),
    .in_clr     (bus.in_stat_clear),
    .out_count  (bus.out_grant_drop)
  );

endmodule

// File: tb/tb_burst_sync_controller.sv
// Scoreboard bench for burst_sync_controller: directed bursts push expected strobes, a negedge monitor pops and compares.
// A second instance with 3-bit statistics shares the stimulus so counter saturation is reachable quickly.
`timescale 1ns/1ps
module tb_burst_sync_controller;

  localparam int         CLK_P  = 10;
  localparam logic [2:0] K_DV   = 3'b001;
  localparam logic [2:0] K_OK   = 3'b010;
  localparam logic [2:0] K_FAIL = 3'b100;
  localparam int         MAX16  = 65535;
  localparam int         MAX3   = 7;

  typedef struct packed {
    logic [2:0]  kind;
    logic        sof;
    logic        eof;
    logic [31:0] cyc;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] cyc;

  ev_t exp_q[$];
  ev_t mon_e;

  int n_chk;
  int n_pass;
  int n_en;
  int exp_lock, exp_fail, exp_drop, exp_lock_s;

  burst_sync_controller_if bus ();
  burst_sync_controller_if #(.STAT_W(3)) bus_s ();

  burst_sync_controller dut (
    .in_clock   (clk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  burst_sync_controller #(.STAT_W(3)) dut_s (
    .in_clock   (clk),
    .in_reset_n (rst_n),
    .bus        (bus_s)
  );

  assign bus_s.in_grant         = bus.in_grant;
  assign bus_s.in_burst_len     = bus.in_burst_len;
  assign bus_s.in_search_win    = bus.in_search_win;
  assign bus_s.in_threshold_cfg = bus.in_threshold_cfg;
  assign bus_s.in_detected      = bus.in_detected;
  assign bus_s.in_stat_clear    = bus.in_stat_clear;

  initial begin
    clk = 1'b0;
    cyc = 0;
  end
  always #(CLK_P/2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic sof, input logic eof,
                         input int c, input int lim);
    ev_t ev;
    if (c < lim) begin
      ev.kind = kind;
      ev.sof  = sof;
      ev.eof  = eof;
      ev.cyc  = 32'(c);
      exp_q.push_back(ev);
    end
  endtask

  // Monitor: every strobe the DUT raises must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.out_sync_enable === 1'b1) n_en++;
    if (bus.out_data_valid || bus.out_burst_ok || bus.out_burst_fail || bus.out_sof || bus.out_eof) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event",
              {bus.out_burst_fail, bus.out_burst_ok, bus.out_data_valid, bus.out_sof, bus.out_eof}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind_sof_eof",
              {bus.out_burst_fail, bus.out_burst_ok, bus.out_data_valid, bus.out_sof, bus.out_eof},
              {mon_e.kind, mon_e.sof, mon_e.eof});
        check("event_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // det < 0: no detect; g1/g2/clr_at/rst_at are cycle offsets from the grant edge, < 0 disables.
  task automatic run_burst(input int len, input int win, input int det,
                           input int g1, input int g2, input int clr_at, input int rst_at);
    int         e, last_c, en_exp, lim;
    logic [6:0] thr0;
    e    = int'(cyc) + 1;
    lim  = (rst_at >= 0) ? e + rst_at : 32'h7fff_ffff;
    thr0 = bus.in_threshold_cfg;
    n_en = 0;
    if (det >= 0) begin
      for (int k = 0; k < len; k++)
        push_ev(K_DV, k == 0, k == len - 1, e + 8 + det + k, lim);
      push_ev(K_OK, 1'b0, 1'b0, e + 8 + det + len, lim);
      last_c = e + 8 + det + len;
      en_exp = det + 1;
    end else begin
      push_ev(K_FAIL, 1'b0, 1'b0, e + 5 + win, lim);
      last_c = e + 5 + win;
      en_exp = win + 1;
    end
    bus.in_burst_len  = 16'(len);
    bus.in_search_win = 8'(win);
    bus.in_grant      = 1'b1;
    tick();
    bus.in_grant         = 1'b0;
    bus.in_threshold_cfg = thr0 ^ 7'h7F;
    check("sync_reset_after_grant", bus.out_sync_reset, 1'b0);
    check("busy_after_grant", bus.out_busy, 1'b1);
    for (int c = e; c < last_c + 2; c++) begin
      if (c == e + 3) check("threshold_held", bus.out_threshold, thr0);
      if (rst_at >= 0 && c == e + rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_output_vector",
              {bus.out_sync_reset, bus.out_sync_enable, bus.out_data_valid, bus.out_sof,
               bus.out_eof, bus.out_busy, bus.out_burst_ok, bus.out_burst_fail}, 8'h80);
        check("rst_threshold", bus.out_threshold, 0);
        check("rst_lock_count", bus.out_lock_count, 0);
        bus.in_detected   = 1'b0;
        bus.in_grant      = 1'b0;
        bus.in_stat_clear = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        exp_lock   = 0;
        exp_fail   = 0;
        exp_drop   = 0;
        exp_lock_s = 0;
        check("rst_queue_drained", exp_q.size(), 0);
        return;
      end
      bus.in_detected   = (det >= 0) && (c == e + 4 + det);
      bus.in_grant      = ((g1 >= 0) && (c + 1 == e + g1)) || ((g2 >= 0) && (c + 1 == e + g2));
      bus.in_stat_clear = (clr_at >= 0) && (c + 1 == e + clr_at);
      tick();
    end
    bus.in_detected   = 1'b0;
    bus.in_grant      = 1'b0;
    bus.in_stat_clear = 1'b0;
    if (g1 >= 0) exp_drop = sat(exp_drop, MAX16);
    if (g2 >= 0) exp_drop = sat(exp_drop, MAX16);
    if (det >= 0) begin
      exp_lock   = sat(exp_lock, MAX16);
      exp_lock_s = sat(exp_lock_s, MAX3);
    end else begin
      exp_fail = sat(exp_fail, MAX16);
    end
    if (clr_at >= 0) begin
      exp_lock   = 0;
      exp_fail   = 0;
      exp_drop   = 0;
      exp_lock_s = 0;
    end
    check("idle_after_burst", bus.out_busy, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    check("enable_cycles", n_en, en_exp);
    check("threshold_reload", bus.out_threshold, thr0 ^ 7'h7F);
    check("lock_count", bus.out_lock_count, exp_lock);
    check("fail_count", bus.out_fail_count, exp_fail);
    check("grant_drop", bus.out_grant_drop, exp_drop);
    check("lock_count_3bit", bus_s.out_lock_count, exp_lock_s);
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    n_en       = 0;
    exp_lock   = 0;
    exp_fail   = 0;
    exp_drop   = 0;
    exp_lock_s = 0;
    rst_n                = 1'b0;
    bus.in_grant         = 1'b0;
    bus.in_burst_len     = '0;
    bus.in_search_win    = '0;
    bus.in_threshold_cfg = 7'h2A;
    bus.in_detected      = 1'b0;
    bus.in_stat_clear    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_output_vector",
          {bus.out_sync_reset, bus.out_sync_enable, bus.out_data_valid, bus.out_sof,
           bus.out_eof, bus.out_busy, bus.out_burst_ok, bus.out_burst_fail}, 8'h80);
    check("reset_threshold", bus.out_threshold, 0);
    check("reset_lock_count", bus.out_lock_count, 0);
    check("reset_fail_count", bus.out_fail_count, 0);
    check("reset_grant_drop", bus.out_grant_drop, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_threshold_load", bus.out_threshold, 7'h2A);

    run_burst(4, 20, 5, -1, -1, -1, -1);   // nominal
    run_burst(4, 3, -1, -1, -1, -1, -1);   // timeout
    run_burst(1, 5, 0, -1, -1, -1, -1);    // len 1: sof and eof together
    run_burst(0, 5, 2, -1, -1, -1, -1);    // len 0: ok without data
    run_burst(2, 3, 3, -1, -1, -1, -1);    // detect on final window cycle
    run_burst(3, 0, -1, -1, -1, -1, -1);   // window 0: one search cycle
    run_burst(4, 20, 5, 15, 17, -1, -1);   // grants in PAYLOAD and on exit cycle
    for (int i = 0; i < 4; i++)
      run_burst(0, 0, 0, -1, -1, -1, -1);  // pushes the 3-bit lock count past saturation
    run_burst(4, 20, 5, -1, -1, -1, 6);    // reset during SEARCH
    run_burst(4, 20, 0, -1, -1, -1, 9);    // reset during PAYLOAD
    run_burst(4, 20, 5, -1, -1, -1, -1);   // nominal after reset
    run_burst(1, 0, 0, -1, -1, 9, -1);     // clear coincident with burst_ok

    tick();
    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
